// File: rtl/shift_issue_stage_pkg.sv
// Shared constants and entry type for the shift issue stage.
package shift_issue_stage_pkg;
  localparam int DATA_WIDTH = 32;

  localparam logic [5:0] FUNCT_SLL  = 6'b000000;
  localparam logic [5:0] FUNCT_SRL  = 6'b000010;
  localparam logic [5:0] FUNCT_SRA  = 6'b000011;
  localparam logic [5:0] FUNCT_SLLV = 6'b000100;
  localparam logic [5:0] FUNCT_SRLV = 6'b000110;
  localparam logic [5:0] FUNCT_SRAV = 6'b000111;

  localparam logic [1:0] SHOP_LEFT   = 2'b00;
  localparam logic [1:0] SHOP_LRIGHT = 2'b10;
  localparam logic [1:0] SHOP_ARIGHT = 2'b11;

  typedef struct packed {
    logic [DATA_WIDTH-1:0] a;
    logic [4:0]            b;
    logic [1:0]            op;
    logic [4:0]            rd;
    logic                  illegal;
  } shift_entry_t;
endpackage

// File: rtl/shift_issue_stage_if.sv
// Upstream instruction handshake and downstream shifter-operand handshake.
interface shift_issue_stage_if #(parameter int CNT_WIDTH = 16) ();
  logic                                      in_valid;
  logic                                      in_ready;
  logic [5:0]                                in_funct;
  logic [4:0]                                in_shamt;
  logic [shift_issue_stage_pkg::DATA_WIDTH-1:0] in_rs;
  logic [shift_issue_stage_pkg::DATA_WIDTH-1:0] in_rt;
  logic [4:0]                                in_rd;
  logic                                      out_valid;
  logic                                      out_ready;
  logic [shift_issue_stage_pkg::DATA_WIDTH-1:0] sh_a;
  logic [4:0]                                sh_b;
  logic [1:0]                                sh_op;
  logic [4:0]                                out_rd;
  logic                                      out_illegal;
  logic [CNT_WIDTH-1:0]                      issue_cnt;

  modport slave (
    input  in_valid, in_funct, in_shamt, in_rs, in_rt, in_rd, out_ready,
    output in_ready, out_valid, sh_a, sh_b, sh_op, out_rd, out_illegal, issue_cnt
  );

  modport master (
    output in_valid, in_funct, in_shamt, in_rs, in_rt, in_rd, out_ready,
    input  in_ready, out_valid, sh_a, sh_b, sh_op, out_rd, out_illegal, issue_cnt
  );
endinterface

// File: rtl/shift_decode.sv
// Combinational funct decode: shift length source, shifter opcode, illegal flag.
module shift_decode
  import shift_issue_stage_pkg::*;
(
  input  logic [5:0] funct,
  input  logic [4:0] shamt,
  input  logic [4:0] rs_lo,
  output logic [4:0] b,
  output logic [1:0] op,
  output logic       illegal
);

  always_comb begin
    b       = '0;
    op      = SHOP_LEFT;
    illegal = 1'b0;
    case (funct)
      FUNCT_SLL:  begin b = shamt; op = SHOP_LEFT;   end
      FUNCT_SRL:  begin b = shamt; op = SHOP_LRIGHT; end
      FUNCT_SRA:  begin b = shamt; op = SHOP_ARIGHT; end
      FUNCT_SLLV: begin b = rs_lo; op = SHOP_LEFT;   end
      FUNCT_SRLV: begin b = rs_lo; op = SHOP_LRIGHT; end
      FUNCT_SRAV: begin b = rs_lo; op = SHOP_ARIGHT; end
      default:    illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/shift_issue_stage.sv
// Shift issue stage: decode, 2-entry skid buffer with registered in_ready,
// and a wrapping count of downstream handshakes.
module shift_issue_stage
  import shift_issue_stage_pkg::*;
#(
  parameter int CNT_WIDTH = 16
) (
  input  logic               clk,
  input  logic               resetn,
  shift_issue_stage_if.slave bus
);

  shift_entry_t         main_q, main_d, skid_q, skid_d, dec_entry;
  logic                 main_valid_q, main_valid_d;
  logic                 skid_valid_q, skid_valid_d;
  logic                 in_ready_q, in_ready_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [4:0]           dec_b;
  logic [1:0]           dec_op;
  logic                 dec_illegal;
  logic                 in_xfer, out_xfer;
  logic                 unused_rs_hi;

  assign unused_rs_hi = ^bus.in_rs[DATA_WIDTH-1:5];

  shift_decode u_decode (
    .funct   (bus.in_funct),
    .shamt   (bus.in_shamt),
    .rs_lo   (bus.in_rs[4:0]),
    .b       (dec_b),
    .op      (dec_op),
    .illegal (dec_illegal)
  );

  assign dec_entry = '{a: bus.in_rt, b: dec_b, op: dec_op, rd: bus.in_rd, illegal: dec_illegal};
  assign in_xfer   = bus.in_valid & in_ready_q;
  assign out_xfer  = main_valid_q & bus.out_ready;

  always_comb begin
    main_d       = main_q;
    skid_d       = skid_q;
    main_valid_d = main_valid_q;
    skid_valid_d = skid_valid_q;
    if (in_xfer) begin
      if (!main_valid_q || out_xfer) begin
        // Older skid occupant must advance first to keep ordering.
        if (skid_valid_q) begin
          main_d = skid_q;
          skid_d = dec_entry;
        end else begin
          main_d = dec_entry;
        end
        main_valid_d = 1'b1;
      end else begin
        skid_d       = dec_entry;
        skid_valid_d = 1'b1;
      end
    end else if (out_xfer) begin
      if (skid_valid_q) begin
        main_d       = skid_q;
        skid_valid_d = 1'b0;
      end else begin
        main_valid_d = 1'b0;
      end
    end
    in_ready_d = ~skid_valid_d;
    cnt_d      = cnt_q + {{(CNT_WIDTH-1){1'b0}}, out_xfer};
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      main_q       <= '0;
      skid_q       <= '0;
      main_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
      in_ready_q   <= 1'b0;
      cnt_q        <= '0;
    end else begin
      main_q       <= main_d;
      skid_q       <= skid_d;
      main_valid_q <= main_valid_d;
      skid_valid_q <= skid_valid_d;
      in_ready_q   <= in_ready_d;
      cnt_q        <= cnt_d;
    end
  end

  assign bus.in_ready    = in_ready_q;
  assign bus.out_valid   = main_valid_q;
  assign bus.sh_a        = main_q.a;
  assign bus.sh_b        = main_q.b;
  assign bus.sh_op       = main_q.op;
  assign bus.out_rd      = main_q.rd;
  assign bus.out_illegal = main_q.illegal;
  assign bus.issue_cnt   = cnt_q;

endmodule

// File: tb/tb_shift_issue_stage.sv
// Scoreboard bench for shift_issue_stage: directed decode, backpressure,
// reset, throughput, illegal funct and counter wrap.
module tb_shift_issue_stage;

  typedef struct {
    logic [31:0] a;
    logic [4:0]  b;
    logic [1:0]  op;
    logic [4:0]  rd;
    logic        ill;
  } exp_t;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  int   checks = 0;
  int   errors = 0;
  exp_t exp_q[$];
  logic [15:0] model_cnt = '0;
  int   run_len = 0;
  int   max_run = 0;

  shift_issue_stage_if #(.CNT_WIDTH(16)) bus ();

  shift_issue_stage #(.CNT_WIDTH(16)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic chk_entry(input string name, input exp_t e);
    chk({name, ".a"},   64'(bus.sh_a),        64'(e.a));
    chk({name, ".b"},   64'(bus.sh_b),        64'(e.b));
    chk({name, ".op"},  64'(bus.sh_op),       64'(e.op));
    chk({name, ".rd"},  64'(bus.out_rd),      64'(e.rd));
    chk({name, ".ill"}, 64'(bus.out_illegal), 64'(e.ill));
  endtask

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic send(input logic [5:0] funct, input logic [4:0] shamt,
                      input logic [31:0] rs, input logic [31:0] rt, input logic [4:0] rd,
                      input logic [4:0] eb, input logic [1:0] eop, input logic eill);
    exp_t e;
    bit   acc = 0;
    int   t = 0;
    bus.in_valid = 1'b1;
    bus.in_funct = funct;
    bus.in_shamt = shamt;
    bus.in_rs    = rs;
    bus.in_rt    = rt;
    bus.in_rd    = rd;
    while (!acc && t < 200) begin
      @(negedge clk);
      acc = bus.in_ready;
      if (acc) begin
        e = '{a: rt, b: eb, op: eop, rd: rd, ill: eill};
        exp_q.push_back(e);
      end
      @(posedge clk); #1;
      t++;
    end
    if (!acc) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: in_ready never high, expected 1");
    end
    bus.in_valid = 1'b0;
  endtask

  always @(negedge clk) begin
    if (!resetn) begin
      run_len = 0;
    end else begin
      run_len = bus.out_valid ? run_len + 1 : 0;
      if (run_len > max_run) max_run = run_len;
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_output: out_valid with empty scoreboard, expected none");
        end else begin
          chk_entry("pop", exp_q.pop_front());
          chk("cnt_track", 64'(bus.issue_cnt), 64'(model_cnt));
          model_cnt = model_cnt + 16'd1;
        end
      end else if (bus.out_valid && exp_q.size() != 0) begin
        chk_entry("hold", exp_q[0]);
      end
    end
  end

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_funct  = '0;
    bus.in_shamt  = '0;
    bus.in_rs     = '0;
    bus.in_rt     = '0;
    bus.in_rd     = '0;
    bus.out_ready = 1'b1;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_issue_cnt", 64'(bus.issue_cnt), 64'd0);
    chk("rst_sh_a",      64'(bus.sh_a),      64'd0);
    chk("rst_illegal",   64'(bus.out_illegal), 64'd0);
    @(negedge clk) resetn = 1'b1;
    @(posedge clk); #1;
    chk("rel_in_ready", 64'(bus.in_ready), 64'd1);

    // sra shamt=4 on 0x80000000, then 1-cycle latency
    send(6'b000011, 5'd4, 32'h0, 32'h8000_0000, 5'd7, 5'd4, 2'b11, 1'b0);
    chk("latency_valid", 64'(bus.out_valid), 64'd1);
    // srlv uses rs[4:0]=3
    send(6'b000110, 5'd0, 32'hFFFF_FFE3, 32'h1234_5678, 5'd9, 5'd3, 2'b10, 1'b0);
    repeat (3) @(posedge clk); #1;
    chk("idle_after_decode", 64'(bus.out_valid), 64'd0);

    // Backpressure: two accepted, third waits
    bus.out_ready = 1'b0;
    send(6'b000000, 5'd1, 32'h0, 32'h0000_0011, 5'd1, 5'd1, 2'b00, 1'b0);
    send(6'b000010, 5'd2, 32'h0, 32'h0000_0022, 5'd2, 5'd2, 2'b10, 1'b0);
    chk("bp_in_ready", 64'(bus.in_ready), 64'd0);
    chk_entry("bp_first", '{a: 32'h11, b: 5'd1, op: 2'b00, rd: 5'd1, ill: 1'b0});
    fork
      send(6'b000111, 5'd0, 32'h0000_001F, 32'h0000_0033, 5'd3, 5'd31, 2'b11, 1'b0);
      begin repeat (3) @(posedge clk); #1; bus.out_ready = 1'b1; end
    join
    repeat (4) @(posedge clk); #1;
    chk("bp_drained", 64'(exp_q.size()), 64'd0);
    chk("bp_cnt", 64'(bus.issue_cnt), 64'd5);

    // Reset mid-stream with both entries full
    bus.out_ready = 1'b0;
    send(6'b000000, 5'd5, 32'h0, 32'hAAAA_5555, 5'd4, 5'd5, 2'b00, 1'b0);
    send(6'b000100, 5'd0, 32'h2, 32'h5555_AAAA, 5'd5, 5'd2, 2'b00, 1'b0);
    #2 resetn = 1'b0;
    #1;
    chk("mid_rst_valid", 64'(bus.out_valid), 64'd0);
    chk("mid_rst_cnt",   64'(bus.issue_cnt), 64'd0);
    chk("mid_rst_sh_a",  64'(bus.sh_a),      64'd0);
    chk("mid_rst_sh_b",  64'(bus.sh_b),      64'd0);
    chk("mid_rst_rd",    64'(bus.out_rd),    64'd0);
    exp_q.delete();
    model_cnt = '0;
    @(negedge clk) resetn = 1'b1;
    @(posedge clk); #1;
    chk("mid_rel_in_ready", 64'(bus.in_ready), 64'd1);
    bus.out_ready = 1'b1;

    // Full throughput
    max_run = 0;
    for (int i = 0; i < 10; i++)
      send(6'b000010, 5'(i), 32'h0, 32'(i * 16 + 1), 5'(i), 5'(i), 2'b10, 1'b0);
    repeat (3) @(posedge clk); #1;
    chk("tput_run", 64'(max_run), 64'd10);
    chk("tput_cnt", 64'(bus.issue_cnt), 64'd10);

    // Illegal funct still passes and counts
    send(6'b100000, 5'd9, 32'h1F, 32'hDEAD_BEEF, 5'd31, 5'd0, 2'b00, 1'b1);
    repeat (2) @(posedge clk); #1;
    chk("ill_cnt", 64'(bus.issue_cnt), 64'd11);

    // Run the counter to its top value, then wrap
    for (int i = 11; i < 65535; i++)
      send(6'b000000, 5'(i), 32'h0, 32'(i), 5'(i), 5'(i), 2'b00, 1'b0);
    repeat (2) @(posedge clk); #1;
    chk("cnt_max", 64'(bus.issue_cnt), 64'hFFFF);
    send(6'b000011, 5'd1, 32'h0, 32'hF000_0000, 5'd2, 5'd1, 2'b11, 1'b0);
    repeat (2) @(posedge clk); #1;
    chk("cnt_wrap", 64'(bus.issue_cnt), 64'h0000);
    chk("final_drained", 64'(exp_q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/shift_issue_stage.md
Name: shift_issue_stage

Overview:
- Pipeline stage directly upstream of the combinational shifter in the execute path.
- Accepts decoded MIPS R-type shift instructions (sll/srl/sra/sllv/srlv/srav) over a valid/ready handshake.
- Selects the shift amount (shamt field or rs[4:0]), encodes the 2-bit shift opcode, and registers the operands and destination register.
- A 2-entry skid buffer gives full throughput with a registered upstream ready.

Parameters:
- DATA_WIDTH, 32, operand width; only 32 is supported.
- CNT_WIDTH, 16, width of the issued-operation counter.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- resetn  in  1  asynchronous, active-low reset.
- in_valid  in  1  upstream holds a valid instruction.
- in_ready  out  1  stage can accept; driven directly from a flop.
- in_funct  in  6  R-type funct field.
- in_shamt  in  5  instruction shamt field.
- in_rs  in  DATA_WIDTH  rs register value.
- in_rt  in  DATA_WIDTH  rt register value; this is the value that gets shifted.
- in_rd  in  5  destination register number.
- out_valid  out  1  shifter operands are valid.
- out_ready  in  1  downstream accepts.
- sh_a  out  DATA_WIDTH  operand to shift; connects to shifter A.
- sh_b  out  5  shift length; connects to shifter B.
- sh_op  out  2  shift opcode: 00 left, 10 logical right, 11 arithmetic right; connects to shifter Shiftop.
- out_rd  out  5  destination register, carried alongside the operands.
- out_illegal  out  1  funct was not one of the six shift codes.
- issue_cnt  out  CNT_WIDTH  count of out handshakes.

Behaviour:
- Reset (resetn=0, asynchronous): all of the following clear to 0 and hold while resetn is low:
  - main_valid, skid_valid, issue_cnt;
  - sh_a, sh_b, sh_op, out_rd, out_illegal.
  - in_ready is 1 on the first edge after reset release.
  - Any in-flight entries are discarded; there is no partial recovery.
- Decode (combinational on the input side, then registered):
  - 000000 sll: b=shamt, op=00.
  - 000010 srl: b=shamt, op=10.
  - 000011 sra: b=shamt, op=11.
  - 000100 sllv: b=rs[4:0], op=00.
  - 000110 srlv: b=rs[4:0], op=10.
  - 000111 srav: b=rs[4:0], op=11.
  - Any other funct: b=0, op=00, illegal=1. The entry is still passed downstream.
  - a=in_rt in all cases. rs[31:5] is ignored.
- Handshake terms:
  - An input transfer is in_valid & in_ready.
  - An output transfer is out_valid & out_ready.
  - out_valid = main_valid.
  - in_ready = ~skid_valid, registered.
- Datapath registers: one main entry and one skid entry, each holding {a, b, op, rd, illegal}.
- Per-edge update rules:
  - Input transfer, and the main entry is empty or an output transfer occurs this cycle: the decoded input loads into main. If skid is also valid, skid loads main first and the input loads into skid; ordering is preserved.
  - Input transfer while main is held (out_valid=1, out_ready=0): the input loads into skid, skid_valid becomes 1, and in_ready drops next cycle.
  - Output transfer with skid valid and no input: skid moves to main, and skid_valid clears.
  - Output transfer with skid empty and no input: main_valid clears.
- Output stability: while out_valid=1 and out_ready=0, the outputs sh_a, sh_b, sh_op, out_rd and out_illegal must not change.
- Latency: 1 cycle from input transfer to out_valid when the stage is empty.
- Throughput: 1 instruction per cycle with no bubbles while out_ready=1.
- Simultaneous input and output transfer with a single occupant: main is replaced by the new entry and main_valid stays 1.
- Upstream is never back-pressured combinationally; in_ready does not depend on out_ready in the same cycle.
- issue_cnt increments by 1 on each output transfer, including illegal entries, and wraps from 2^CNT_WIDTH-1 to 0.
- Inputs are ignored when in_valid=0, and whenever in_ready=0.

Decomposition:
- A shared package/header holds:
  - the funct constants (FUNCT_SLL, FUNCT_SRL, FUNCT_SRA, FUNCT_SLLV, FUNCT_SRLV, FUNCT_SRAV);
  - the shift opcode constants (SHOP_LEFT=00, SHOP_LRIGHT=10, SHOP_ARIGHT=11);
  - DATA_WIDTH.
- One sub-module: shift_decode. It is purely combinational, mapping funct/shamt/rs to b, op and illegal.
- The skid buffer and counter are written inline in shift_issue_stage.

Test Plan:
- Reset mid-stream: fill both entries, then pulse resetn low between edges. Required: out_valid, issue_cnt and all operand outputs go to 0 immediately, and in_ready=1 after release.
- sra decode: funct=000011, shamt=4, rt=0x80000000, out_ready=1. Required: next cycle out_valid=1, sh_a=0x80000000, sh_b=4, sh_op=11, illegal=0.
- srlv decode: funct=000110, rs=0xFFFFFFE3, rt=0x12345678. Required: sh_b=3 (rs[4:0]), sh_op=10.
- Backpressure: hold out_ready=0 and offer three back-to-back instructions. Required:
  - the first two are accepted and in_ready=0 afterwards;
  - the outputs hold the first instruction stably;
  - after releasing out_ready, the outputs follow in order 1, 2, 3 with no loss or duplication.
- Full throughput: stream 10 instructions with out_ready=1 throughout. Required: out_valid is high for 10 consecutive cycles and issue_cnt=10.
- Illegal funct and counter wrap: send funct=100000. Required: out_illegal=1, sh_b=0, sh_op=00, and the counter still increments. Preload or run issue_cnt to 0xFFFF; one more output transfer must give 0x0000.
